// File: rtl/img_rom_arbiter.sv
// Shares the single-port image ROM between the display scan reader (strict priority)
// and an auxiliary req/gnt reader with out-of-range flagging and a starvation monitor.
module img_rom_arbiter #(
    parameter int          ADDR_W     = 17,
    parameter int          DATA_W     = 16,
    parameter int unsigned ROM_DEPTH  = 76800,
    parameter int          STARVE_MAX = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_valid,
    output logic [DATA_W-1:0] aux_data,
    output logic              aux_err,
    output logic              aux_starved,
    input  logic              starve_clr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_DISP    = 2'd1,
        OWN_AUX     = 2'd2,
        OWN_AUX_OOR = 2'd3
    } owner_e;

    localparam logic [ADDR_W:0] ROM_DEPTH_EXT = ROM_DEPTH[ADDR_W:0];
    localparam logic [7:0]      STARVE_LAST   = 8'(STARVE_MAX - 1);
    localparam logic [7:0]      WAIT_SAT      = 8'hFF;

    owner_e            owner_d, owner_q;
    logic [ADDR_W-1:0] last_addr_d, last_addr_q;
    logic [DATA_W-1:0] disp_data_d, disp_data_q;
    logic [DATA_W-1:0] aux_data_d, aux_data_q;
    logic [7:0]        wait_cnt_d, wait_cnt_q;
    logic              aux_starved_d, aux_starved_q;
    logic              aux_in_range;
    logic              aux_waiting;
    logic              starve_set;

    // Issue decision: DISP wins outright; the address bus parks on its last value when idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        owner_d      = OWN_NONE;
        aux_gnt      = 1'b0;
        rom_addr     = last_addr_q;
        aux_in_range = ({1'b0, aux_addr} < ROM_DEPTH_EXT);
        if (!reset) begin
            rom_addr = '0;
        end else if (disp_req) begin
            owner_d  = OWN_DISP;
            rom_addr = disp_addr;
        end else if (aux_req) begin
            aux_gnt = 1'b1;
            if (aux_in_range) begin
                owner_d  = OWN_AUX;
                rom_addr = aux_addr;
            end else begin
                owner_d  = OWN_AUX_OOR;
                rom_addr = '0;
            end
        end
        last_addr_d = rom_addr;
    end

    // Return path: the owner recorded last cycle claims the ROM data; a reset cycle
    // squashes whatever read was in flight.
    always_comb begin
        disp_valid = reset && (owner_q == OWN_DISP);
        aux_valid  = reset && ((owner_q == OWN_AUX) || (owner_q == OWN_AUX_OOR));
        aux_err    = reset && (owner_q == OWN_AUX_OOR);
        disp_data  = disp_valid ? rom_data : disp_data_q;
        aux_data   = aux_data_q;
        if (aux_valid) begin
            aux_data = aux_err ? '0 : rom_data;
        end
        disp_data_d = disp_data;
        aux_data_d  = aux_data;
    end

    // Starvation monitor: counts consecutive ungranted AUX cycles within one request.
    always_comb begin
        aux_waiting = aux_req && !aux_gnt;
        wait_cnt_d  = '0;
        if (aux_waiting) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
        starve_set    = aux_waiting && (wait_cnt_q == STARVE_LAST);
        aux_starved_d = aux_starved_q;
        if (starve_set) begin
            aux_starved_d = 1'b1;
        end else if (starve_clr) begin
            aux_starved_d = 1'b0;
        end
    end

    assign aux_starved = aux_starved_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples
        // the values from before this edge regardless of statement order.
        if (!reset) begin
            owner_q       <= OWN_NONE;
            last_addr_q   <= '0;
            disp_data_q   <= '0;
            aux_data_q    <= '0;
            wait_cnt_q    <= '0;
            aux_starved_q <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            last_addr_q   <= last_addr_d;
            disp_data_q   <= disp_data_d;
            aux_data_q    <= aux_data_d;
            wait_cnt_q    <= wait_cnt_d;
            aux_starved_q <= aux_starved_d;
        end
    end

endmodule

// File: tb/tb_img_rom_arbiter.sv
// Self-checking bench for img_rom_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a transaction-level model.
module tb_img_rom_arbiter;

    localparam int          ADDR_W     = 17;
    localparam int          DATA_W     = 16;
    localparam int unsigned ROM_DEPTH  = 76800;
    localparam int          STARVE_MAX = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              aux_req;
    logic [ADDR_W-1:0] aux_addr;
    logic              aux_gnt;
    logic              aux_valid;
    logic [DATA_W-1:0] aux_data;
    logic              aux_err;
    logic              aux_starved;
    logic              starve_clr;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    int checks = 0;
    int errors = 0;

    img_rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_DEPTH(ROM_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt),
        .aux_valid(aux_valid), .aux_data(aux_data), .aux_err(aux_err),
        .aux_starved(aux_starved), .starve_clr(starve_clr),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // ROM contents are a fixed hash of the address; the ROM registers its address.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = 32'(a) * 32'h9E37_79B1;
        return x[31:16] ^ a[15:0];
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding read, held data, and a count of
    // consecutive cycles the current AUX request has waited.
    bit                m_ok = 1'b0;
    int                m_pend;          // 0 none, 1 display read, 2 aux read
    logic [ADDR_W-1:0] m_pend_addr;
    bit                m_pend_oor;
    logic [ADDR_W-1:0] m_last;
    logic [DATA_W-1:0] m_disp_data;
    logic [DATA_W-1:0] m_aux_data;
    int                m_waited;
    bit                m_starved;

    always @(negedge clk) begin
        bit                e_gnt, e_dv, e_av, e_err;
        logic [ADDR_W-1:0] e_addr;
        bit                oor;
        oor   = (32'(aux_addr) >= ROM_DEPTH);
        e_gnt = reset && !disp_req && aux_req;
        if (!reset)        e_addr = '0;
        else if (disp_req) e_addr = disp_addr;
        else if (aux_req)  e_addr = oor ? '0 : aux_addr;
        else               e_addr = m_last;
        e_dv  = reset && (m_pend == 1);
        e_av  = reset && (m_pend == 2);
        e_err = e_av && m_pend_oor;
        if (e_dv) m_disp_data = rom_word(m_pend_addr);
        if (e_av) m_aux_data  = m_pend_oor ? '0 : rom_word(m_pend_addr);

        if (m_ok) begin
            check("mdl_aux_gnt",     32'(aux_gnt),     32'(e_gnt));
            check("mdl_rom_addr",    32'(rom_addr),    32'(e_addr));
            check("mdl_disp_valid",  32'(disp_valid),  32'(e_dv));
            check("mdl_disp_data",   32'(disp_data),   32'(m_disp_data));
            check("mdl_aux_valid",   32'(aux_valid),   32'(e_av));
            check("mdl_aux_data",    32'(aux_data),    32'(m_aux_data));
            check("mdl_aux_err",     32'(aux_err),     32'(e_err));
            check("mdl_aux_starved", 32'(aux_starved), 32'(m_starved));
        end

        if (!reset) begin
            m_ok        = 1'b1;
            m_pend      = 0;
            m_pend_oor  = 1'b0;
            m_pend_addr = '0;
            m_last      = '0;
            m_disp_data = '0;
            m_aux_data  = '0;
            m_waited    = 0;
            m_starved   = 1'b0;
        end else begin
            m_pend      = disp_req ? 1 : (aux_req ? 2 : 0);
            m_pend_addr = disp_req ? disp_addr : aux_addr;
            m_pend_oor  = !disp_req && oor;
            m_last      = e_addr;
            if (aux_req && !e_gnt) begin
                m_waited++;
                if (m_waited == STARVE_MAX) m_starved = 1'b1;
                else if (starve_clr)        m_starved = 1'b0;
            end else begin
                m_waited = 0;
                if (starve_clr) m_starved = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  dens;
        bit  granted_prev;

        // Reset held 3 edges with both requesters active.
        reset = 1'b0; disp_req = 1'b1; aux_req = 1'b1;
        disp_addr = 17'd3; aux_addr = 17'h40; starve_clr = 1'b0;
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            sample();
            check("rst_aux_gnt",    32'(aux_gnt),     32'd0);
            check("rst_disp_valid", 32'(disp_valid),  32'd0);
            check("rst_aux_valid",  32'(aux_valid),   32'd0);
            check("rst_aux_err",    32'(aux_err),     32'd0);
            check("rst_starved",    32'(aux_starved), 32'd0);
            check("rst_disp_data",  32'(disp_data),   32'd0);
            check("rst_aux_data",   32'(aux_data),    32'd0);
            check("rst_rom_addr",   32'(rom_addr),    32'd0);
            next_cycle();
        end
        reset = 1'b1; disp_req = 1'b0; aux_req = 1'b0;
        sample();
        check("post_rst_no_valid", 32'(disp_valid), 32'd0);
        next_cycle();
        disp_req = 1'b1; disp_addr = 17'd5;
        sample();
        check("first_req_valid", 32'(disp_valid), 32'd0);
        check("first_req_addr",  32'(rom_addr),   32'd5);
        next_cycle();
        disp_req = 1'b0;
        sample();
        check("first_valid", 32'(disp_valid), 32'd1);
        check("first_data",  32'(disp_data),  32'(rom_word(17'd5)));

        // Display stream of addresses 0..9.
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            disp_req  = (i < 10);
            disp_addr = 17'(i);
            sample();
            check("stream_valid", 32'(disp_valid), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) check("stream_data", 32'(disp_data), 32'(rom_word(17'(i - 1))));
        end
        next_cycle();
        disp_req = 1'b0;
        sample();
        check("stream_hold_valid", 32'(disp_valid), 32'd0);
        check("stream_hold_data",  32'(disp_data),  32'(rom_word(17'd9)));

        // Contention: AUX waits behind five display reads.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            disp_req = 1'b1; disp_addr = 17'(20 + k);
            aux_req = 1'b1; aux_addr = 17'h100;
            sample();
            check("cont_no_gnt", 32'(aux_gnt), 32'd0);
        end
        next_cycle();
        disp_req = 1'b0;
        sample();
        check("cont_gnt",       32'(aux_gnt),    32'd1);
        check("cont_gnt_addr",  32'(rom_addr),   32'h100);
        check("cont_last_disp", 32'(disp_data),  32'(rom_word(17'd24)));
        next_cycle();
        aux_req = 1'b0;
        sample();
        check("cont_aux_valid", 32'(aux_valid), 32'd1);
        check("cont_aux_data",  32'(aux_data),  32'(rom_word(17'h100)));
        check("cont_aux_err",   32'(aux_err),   32'd0);
        check("cont_gnt_once",  32'(aux_gnt),   32'd0);

        // Out-of-range AUX read at the first invalid address.
        next_cycle();
        aux_req = 1'b1; aux_addr = 17'(ROM_DEPTH);
        sample();
        check("oor_gnt",      32'(aux_gnt),  32'd1);
        check("oor_rom_addr", 32'(rom_addr), 32'd0);
        next_cycle();
        aux_req = 1'b0;
        sample();
        check("oor_valid", 32'(aux_valid), 32'd1);
        check("oor_err",   32'(aux_err),   32'd1);
        check("oor_data",  32'(aux_data),  32'd0);

        // Starvation: 70 display cycles hold AUX off.
        next_cycle();
        starve_clr = 1'b1;
        next_cycle();
        starve_clr = 1'b0;
        for (int k = 0; k < 70; k++) begin
            next_cycle();
            disp_req = 1'b1; disp_addr = 17'(k);
            aux_req = 1'b1; aux_addr = 17'h200;
            sample();
            if (k == 63) check("starve_before", 32'(aux_starved), 32'd0);
            if (k == 64) check("starve_set",    32'(aux_starved), 32'd1);
        end
        next_cycle();
        disp_req = 1'b0;
        sample();
        check("starve_gnt", 32'(aux_gnt), 32'd1);
        next_cycle();
        aux_req = 1'b0; starve_clr = 1'b1;
        sample();
        check("starve_sticky",  32'(aux_starved), 32'd1);
        check("starve_aux_dat", 32'(aux_data),    32'(rom_word(17'h200)));
        next_cycle();
        starve_clr = 1'b0;
        sample();
        check("starve_cleared", 32'(aux_starved), 32'd0);

        // Abandon: AUX drops its request before any grant.
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            disp_req = (k < 3); disp_addr = 17'd11;
            aux_req  = (k < 3); aux_addr  = 17'h300;
            sample();
            check("abandon_no_gnt",   32'(aux_gnt),   32'd0);
            check("abandon_no_valid", 32'(aux_valid), 32'd0);
        end

        // Reset the cycle after a display issue discards the read.
        next_cycle();
        disp_req = 1'b1; disp_addr = 17'd7;
        next_cycle();
        reset = 1'b0; disp_req = 1'b0;
        sample();
        check("midrst_no_valid", 32'(disp_valid), 32'd0);
        next_cycle();
        reset = 1'b1;
        sample();
        check("midrst_after_valid", 32'(disp_valid), 32'd0);
        check("midrst_after_data",  32'(disp_data),  32'd0);

        // Randomized traffic obeying the AUX hold-until-grant protocol.
        dens = 50;
        granted_prev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            if (n % 150 == 0) dens = (n % 600 == 0) ? 100 : int'($urandom_range(0, 100));
            reset      = ($urandom_range(0, 299) != 0);
            disp_req   = (int'($urandom_range(0, 99)) < dens);
            disp_addr  = 17'($urandom_range(0, ROM_DEPTH - 1));
            starve_clr = ($urandom_range(0, 49) == 0);
            if (aux_req && !granted_prev) begin
                if ($urandom_range(0, 39) == 0) aux_req = 1'b0;
            end else begin
                aux_req  = ($urandom_range(0, 2) != 0);
                aux_addr = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(ROM_DEPTH, 131071))
                                                       : 17'($urandom_range(0, ROM_DEPTH - 1));
            end
            granted_prev = reset && !disp_req && aux_req;
        end

        next_cycle();
        reset = 1'b1; disp_req = 1'b0; aux_req = 1'b0; starve_clr = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
